// File: rtl/slot_pkg.sv
// Shared types and LFSR tap table for the slot reel bank.
package slot_pkg;

    localparam int unsigned MAX_REELS = 8;
    localparam int unsigned MAX_WIDTH = 8;

    typedef enum logic [1:0] {IDLE, SPIN, STOPPING, DONE} slot_state_t;

    // Tap mask for a maximal-length Fibonacci LFSR of the given width.
    function automatic logic [MAX_WIDTH-1:0] lfsr_taps(input int unsigned width);
        logic [MAX_WIDTH-1:0] mask;
        mask = '0;
        case (width)
            3:       mask = 8'b0000_0110;
            4:       mask = 8'b0000_1100;
            5:       mask = 8'b0001_0100;
            6:       mask = 8'b0011_0000;
            7:       mask = 8'b0110_0000;
            8:       mask = 8'b1011_1000;
            default: mask = '0;
        endcase
        return mask;
    endfunction

endpackage

// File: rtl/slot_lfsr_reel.sv
// One reel: a WIDTH-bit Fibonacci LFSR loaded with its seed on reset, stepping when step=1.
module slot_lfsr_reel
    import slot_pkg::*;
#(
    parameter int unsigned WIDTH = 4
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic [WIDTH-1:0] seed,
    input  logic             step,
    output logic [WIDTH-1:0] value
);

    localparam logic [MAX_WIDTH-1:0] TAPS     = lfsr_taps(WIDTH);
    localparam logic [WIDTH-1:0]     TAP_MASK = TAPS[WIDTH-1:0];

    logic [WIDTH-1:0] sr_q;
    logic [WIDTH-1:0] seed_safe;
    logic             fb;

    // All-zero is the LFSR lock-up state, so never load it.
    assign seed_safe = (seed == '0) ? {{(WIDTH-1){1'b0}}, 1'b1} : seed;
    assign fb        = ^(sr_q & TAP_MASK);

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            sr_q <= seed_safe;
        end else if (step) begin
            sr_q <= {sr_q[WIDTH-2:0], fb};
        end
    end

    assign value = sr_q;

endmodule

// File: rtl/slot_reel_bank.sv
// Bank of NUM_REELS LFSR reels spun together and frozen one by one after stop.
// Optional `win` output (all reels equal at done) enabled by SLOT_BANK_WIN_DETECT_EN.
module slot_reel_bank
    import slot_pkg::*;
#(
    parameter int unsigned                 NUM_REELS = 3,
    parameter int unsigned                 WIDTH     = 4,
    parameter logic [NUM_REELS*WIDTH-1:0]  SEEDS     = 12'h7A4,
    parameter int unsigned                 STOP_GAP  = 4,
    parameter int unsigned                 MIN_SPIN  = 8
) (
    input  logic                         clk,
    input  logic                         reset_n,
    input  logic                         start,
    input  logic                         stop,
    output logic [NUM_REELS*WIDTH-1:0]   reel_values,
    output logic [NUM_REELS-1:0]         reel_frozen,
    output logic                         busy,
`ifdef SLOT_BANK_WIN_DETECT_EN
    output logic                         win,
`endif
    output logic                         done
);

    localparam int unsigned SPIN_W = $clog2(MIN_SPIN + 1);
    localparam int unsigned GAP_W  = $clog2(STOP_GAP + 1);
    localparam int unsigned IDX_W  = (NUM_REELS > 1) ? $clog2(NUM_REELS) : 1;

    localparam logic [SPIN_W-1:0] MIN_CNT  = SPIN_W'(MIN_SPIN);
    localparam logic [GAP_W-1:0]  GAP_LAST = GAP_W'(STOP_GAP - 1);
    localparam logic [IDX_W-1:0]  IDX_LAST = IDX_W'(NUM_REELS - 1);

    slot_state_t           state_q;
    logic [NUM_REELS-1:0]  frozen_q;
    logic                  busy_q;
    logic                  done_q;
    logic                  stop_pending_q;
    logic [SPIN_W-1:0]     spin_cnt_q;
    logic [GAP_W-1:0]      gap_cnt_q;
    logic [IDX_W-1:0]      reel_idx_q;

    logic [NUM_REELS-1:0]  freeze_now;
    logic                  last_freeze;
    logic [NUM_REELS-1:0]  step;

    // A reel freezing on this edge must not step on it.
    always_comb begin
        freeze_now  = '0;
        last_freeze = 1'b0;
        if (state_q == SPIN && stop_pending_q && spin_cnt_q >= MIN_CNT) begin
            freeze_now[0] = 1'b1;
            last_freeze   = (NUM_REELS == 1);
        end else if (state_q == STOPPING && gap_cnt_q == GAP_LAST) begin
            for (int k = 0; k < NUM_REELS; k++) begin
                if (reel_idx_q == IDX_W'(k)) begin
                    freeze_now[k] = 1'b1;
                end
            end
            last_freeze = (reel_idx_q == IDX_LAST);
        end
    end

    for (genvar k = 0; k < NUM_REELS; k++) begin : g_reel
        assign step[k] = busy_q && !frozen_q[k] && !freeze_now[k];

        slot_lfsr_reel #(
            .WIDTH (WIDTH)
        ) u_reel (
            .clk     (clk),
            .reset_n (reset_n),
            .seed    (SEEDS[k*WIDTH +: WIDTH]),
            .step    (step[k]),
            .value   (reel_values[k*WIDTH +: WIDTH])
        );
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q        <= IDLE;
            frozen_q       <= '1;
            busy_q         <= 1'b0;
            done_q         <= 1'b0;
            stop_pending_q <= 1'b0;
            spin_cnt_q     <= '0;
            gap_cnt_q      <= '0;
            reel_idx_q     <= '0;
        end else begin
            done_q   <= 1'b0;
            frozen_q <= frozen_q | freeze_now;
            unique case (state_q)
                IDLE: begin
                    stop_pending_q <= 1'b0;
                    if (start) begin
                        state_q    <= SPIN;
                        frozen_q   <= '0;
                        spin_cnt_q <= '0;
                        busy_q     <= 1'b1;
                    end
                end
                SPIN: begin
                    if (spin_cnt_q < MIN_CNT) begin
                        spin_cnt_q <= spin_cnt_q + 1'b1;
                    end
                    if (stop) begin
                        stop_pending_q <= 1'b1;
                    end
                    if (freeze_now[0]) begin
                        gap_cnt_q  <= '0;
                        reel_idx_q <= IDX_W'(1);
                        if (last_freeze) begin
                            state_q <= DONE;
                            busy_q  <= 1'b0;
                            done_q  <= 1'b1;
                        end else begin
                            state_q <= STOPPING;
                        end
                    end
                end
                STOPPING: begin
                    if (gap_cnt_q == GAP_LAST) begin
                        gap_cnt_q  <= '0;
                        reel_idx_q <= reel_idx_q + 1'b1;
                        if (last_freeze) begin
                            state_q <= DONE;
                            busy_q  <= 1'b0;
                            done_q  <= 1'b1;
                        end
                    end else begin
                        gap_cnt_q <= gap_cnt_q + 1'b1;
                    end
                end
                DONE: begin
                    state_q        <= IDLE;
                    reel_idx_q     <= '0;
                    stop_pending_q <= 1'b0;
                end
            endcase
        end
    end

`ifdef SLOT_BANK_WIN_DETECT_EN
    logic all_equal;

    // Frozen reels no longer move, so current values equal the values shown at done.
    always_comb begin
        all_equal = 1'b1;
        for (int k = 1; k < NUM_REELS; k++) begin
            if (reel_values[k*WIDTH +: WIDTH] != reel_values[0 +: WIDTH]) begin
                all_equal = 1'b0;
            end
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            win <= 1'b0;
        end else if (state_q == IDLE && start) begin
            win <= 1'b0;
        end else if (last_freeze) begin
            win <= all_equal;
        end
    end
`endif

    assign reel_frozen = frozen_q;
    assign busy        = busy_q;
    assign done        = done_q;

endmodule
